// File: rtl/cp0_reg_pkg.sv
// cp0_reg_pkg: shared constants for the CP0 register block.
//   - CP0 register addresses
//   - excepttype codes from the exception unit and ExcCode values
//   - reset value of Status and the general exception vector
package cp0_reg_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'hbfc0_0380;

  // Software-writable bit masks
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  localparam logic [31:0] ET_NONE = 32'h0;
  localparam logic [31:0] ET_INT  = 32'h1;
  localparam logic [31:0] ET_ADEL = 32'h4;
  localparam logic [31:0] ET_ADES = 32'h5;
  localparam logic [31:0] ET_SYS  = 32'h8;
  localparam logic [31:0] ET_BP   = 32'h9;
  localparam logic [31:0] ET_RI   = 32'ha;
  localparam logic [31:0] ET_OV   = 32'hc;
  localparam logic [31:0] ET_ERET = 32'he;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // ExcCode is the excepttype value itself, except interrupts map to 0
  function automatic logic [4:0] exc_code(input logic [31:0] et);
    return (et == ET_INT) ? EXC_INT : et[4:0];
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer.
//   clk, rst         clock, async active-high reset
//   count_we         load Count from wdata (also clears the half-rate tick)
//   compare_we       load Compare from wdata (also clears the interrupt)
//   wdata            write data
//   count, compare   register values
//   timer_int        sticky timer interrupt
// Optional feature: CP0_TIMER_INT_EN enables the timer interrupt; when
// undefined timer_int is tied low.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      compare <= '0;
      tick    <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        tick  <= 1'b0;
      end else begin
        tick <= ~tick;
        if (tick) count <= count + 32'd1;
      end
      if (compare_we) compare <= wdata;
    end
  end

`ifdef CP0_TIMER_INT_EN
  // Compare write wins over a same-cycle match
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timer_int <= 1'b0;
    else if (compare_we)
      timer_int <= 1'b0;
    else if ((count == compare) && (compare != 32'd0))
      timer_int <= 1'b1;
  end
`else
  assign timer_int = 1'b0;
`endif

endmodule

// File: rtl/cp0_reg.sv
// cp0_reg: MIPS-style coprocessor 0 register block.
//   clk, rst                 clock, async active-high reset
//   we_i, waddr_i, wdata_i   mtc0 write port
//   raddr_i, rdata_o         mfc0 combinational read port
//   int_i                    hardware interrupt lines
//   excepttype_i, pc_i, in_delayslot_i, bad_addr_i   exception info
//   status_o .. badvaddr_o   register values
//   timer_int_o              timer interrupt pending
// Optional feature: CP0_TIMER_INT_EN (timer interrupt; otherwise Cause[15]
// follows int_i[5]).
module cp0_reg
  import cp0_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] rdata_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  logic [31:0] status_n, cause_n, epc_n, badvaddr_n;
  logic [5:0]  hw_ip;
  logic        is_exc, is_eret;

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (we_i && (waddr_i == CP0_COUNT)),
    .compare_we (we_i && (waddr_i == CP0_COMPARE)),
    .wdata      (wdata_i),
    .count      (count_o),
    .compare    (compare_o),
    .timer_int  (timer_int_o)
  );

`ifdef CP0_TIMER_INT_EN
  assign hw_ip = {timer_int_o, int_i[4:0]};
`else
  assign hw_ip = int_i;
`endif

  assign is_eret = (excepttype_i == ET_ERET);
  assign is_exc  = (excepttype_i != ET_NONE) && !is_eret;

  // Software write first, exception fields overlaid afterwards
  always_comb begin
    status_n   = status_o;
    cause_n    = cause_o;
    epc_n      = epc_o;
    badvaddr_n = badvaddr_o;

    if (we_i) begin
      case (waddr_i)
        CP0_STATUS: status_n = (status_o & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
        CP0_CAUSE:  cause_n  = (cause_o & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
        CP0_EPC:    epc_n    = wdata_i;
        default: ;
      endcase
    end

    cause_n[15:10] = hw_ip;

    if (is_exc) begin
      // EPC/BD only captured on the first-level exception (EXL clear before)
      if (!status_o[1]) begin
        epc_n      = in_delayslot_i ? (pc_i - 32'd4) : pc_i;
        cause_n[31] = in_delayslot_i;
      end
      status_n[1]   = 1'b1;
      cause_n[6:2]  = exc_code(excepttype_i);
      if ((excepttype_i == ET_ADEL) || (excepttype_i == ET_ADES))
        badvaddr_n = bad_addr_i;
    end else if (is_eret) begin
      status_n[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_o   <= STATUS_RESET;
      cause_o    <= '0;
      epc_o      <= '0;
      badvaddr_o <= '0;
    end else begin
      status_o   <= status_n;
      cause_o    <= cause_n;
      epc_o      <= epc_n;
      badvaddr_o <= badvaddr_n;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      CP0_BADVADDR: rdata_o = badvaddr_o;
      CP0_COUNT:    rdata_o = count_o;
      CP0_COMPARE:  rdata_o = compare_o;
      CP0_STATUS:   rdata_o = status_o;
      CP0_CAUSE:    rdata_o = cause_o;
      CP0_EPC:      rdata_o = epc_o;
      default:      rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed self-checking bench for cp0_reg.
// Build with +define+CP0_TIMER_INT_EN to exercise the timer interrupt.
module tb_cp0_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] rdata_o, status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o;
  logic        timer_int_o;

  int n_checks = 0;
  int n_fail   = 0;

  cp0_reg dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .int_i(int_i), .excepttype_i(excepttype_i), .pc_i(pc_i),
    .in_delayslot_i(in_delayslot_i), .bad_addr_i(bad_addr_i), .rdata_o(rdata_o),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .count_o(count_o),
    .compare_o(compare_o), .badvaddr_o(badvaddr_o), .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we_i = 0; waddr_i = 0; wdata_i = 0; excepttype_i = 0;
    pc_i = 0; in_delayslot_i = 0; bad_addr_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    int_i = 0; raddr_i = 0;
    rst = 1;
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    int_i = 0; raddr_i = 0;
    rst = 1;
    step(); step();
    n_checks++;
    if (status_o !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_status got=%h exp=%h", status_o, 32'h0040_0000); end
    n_checks++;
    if ({cause_o, epc_o, count_o, compare_o, badvaddr_o} !== 160'd0) begin
      n_fail++; $display("FAIL reset_zero cause=%h epc=%h count=%h cmp=%h bva=%h exp=0", cause_o, epc_o, count_o, compare_o, badvaddr_o);
    end
    n_checks++;
    if (timer_int_o !== 1'b0) begin n_fail++; $display("FAIL reset_tint got=%b exp=0", timer_int_o); end
    rst = 0;
    for (int i = 0; i < 10; i++) step();
    raddr_i = 5'd9;
    #1;
    n_checks++;
    if (count_o !== 32'd5) begin n_fail++; $display("FAIL idle_count got=%h exp=5", count_o); end
    n_checks++;
    if (rdata_o !== 32'd5) begin n_fail++; $display("FAIL read_count got=%h exp=5", rdata_o); end
    n_checks++;
    if (status_o !== 32'h0040_0000) begin n_fail++; $display("FAIL idle_status got=%h exp=00400000", status_o); end
    raddr_i = 5'd3;
    #1;
    n_checks++;
    if (rdata_o !== 32'd0) begin n_fail++; $display("FAIL read_unmapped got=%h exp=0", rdata_o); end
  endtask

  task automatic test_status_int();
    we_i = 1; waddr_i = 5'd12; wdata_i = 32'h0000_ff01; int_i = 6'b000001;
    step();
    idle_inputs();
    raddr_i = 5'd12;
    #1;
    n_checks++;
    if (cause_o[10] !== 1'b1) begin n_fail++; $display("FAIL cause_ip2 got=%b exp=1", cause_o[10]); end
    // BEV is not writable and keeps its reset value
    n_checks++;
    if (rdata_o !== 32'h0040_ff01) begin n_fail++; $display("FAIL status_rd got=%h exp=0040ff01", rdata_o); end
    n_checks++;
    if (rdata_o[15:0] !== 16'hff01) begin n_fail++; $display("FAIL status_fields got=%h exp=ff01", rdata_o[15:0]); end
    we_i = 1; waddr_i = 5'd13; wdata_i = 32'hffff_ffff;
    step();
    idle_inputs();
    n_checks++;
    if (cause_o !== 32'h0000_0700) begin n_fail++; $display("FAIL cause_wmask got=%h exp=00000700", cause_o); end
    we_i = 1; waddr_i = 5'd13; wdata_i = 32'h0; int_i = 0;
    step();
    idle_inputs();
    n_checks++;
    if (cause_o !== 32'h0) begin n_fail++; $display("FAIL cause_clear got=%h exp=0", cause_o); end
    we_i = 1; waddr_i = 5'd8; wdata_i = 32'hdead_beef;
    step();
    idle_inputs();
    n_checks++;
    if (badvaddr_o !== 32'h0) begin n_fail++; $display("FAIL bva_ro got=%h exp=0", badvaddr_o); end
  endtask

  task automatic test_exception();
    excepttype_i = 32'hc; pc_i = 32'hbfc0_0100; in_delayslot_i = 1;
    step();
    idle_inputs();
    n_checks++;
    if (epc_o !== 32'hbfc0_00fc) begin n_fail++; $display("FAIL ov_epc got=%h exp=bfc000fc", epc_o); end
    n_checks++;
    if ({cause_o[31], cause_o[6:2]} !== {1'b1, 5'h0c}) begin n_fail++; $display("FAIL ov_cause got=%h exp_bd=1 exc=0c", cause_o); end
    n_checks++;
    if (status_o !== 32'h0040_ff03) begin n_fail++; $display("FAIL ov_status got=%h exp=0040ff03", status_o); end
  endtask

  task automatic test_nested();
    excepttype_i = 32'h8; pc_i = 32'h8000_1000; in_delayslot_i = 0;
    step();
    idle_inputs();
    n_checks++;
    if (epc_o !== 32'hbfc0_00fc) begin n_fail++; $display("FAIL nest_epc got=%h exp=bfc000fc", epc_o); end
    n_checks++;
    if ({cause_o[31], cause_o[6:2]} !== {1'b1, 5'h08}) begin n_fail++; $display("FAIL nest_cause got=%h exp_bd=1 exc=08", cause_o); end
    excepttype_i = 32'he;
    step();
    idle_inputs();
    n_checks++;
    if (status_o !== 32'h0040_ff01) begin n_fail++; $display("FAIL eret_status got=%h exp=0040ff01", status_o); end
    n_checks++;
    if (epc_o !== 32'hbfc0_00fc || cause_o[6:2] !== 5'h08) begin n_fail++; $display("FAIL eret_hold epc=%h exc=%h exp=bfc000fc/08", epc_o, cause_o[6:2]); end
  endtask

  task automatic test_write_exc();
    we_i = 1; waddr_i = 5'd14; wdata_i = 32'h1234_5678;
    excepttype_i = 32'h4; pc_i = 32'h0040_0020; bad_addr_i = 32'h0000_0003;
    step();
    idle_inputs();
    n_checks++;
    if (epc_o !== 32'h0040_0020) begin n_fail++; $display("FAIL wrexc_epc got=%h exp=00400020", epc_o); end
    n_checks++;
    if (badvaddr_o !== 32'h0000_0003) begin n_fail++; $display("FAIL wrexc_bva got=%h exp=00000003", badvaddr_o); end
    n_checks++;
    if ({cause_o[31], cause_o[6:2], status_o[1]} !== {1'b0, 5'h04, 1'b1}) begin n_fail++; $display("FAIL wrexc_fields cause=%h status=%h", cause_o, status_o); end
    excepttype_i = 32'he;
    step();
    // Interrupt exception reports ExcCode 0; non-address exceptions keep BadVAddr
    excepttype_i = 32'h1; pc_i = 32'h8000_0040; bad_addr_i = 32'hffff_0000;
    step();
    idle_inputs();
    n_checks++;
    if ({cause_o[6:2], epc_o, badvaddr_o} !== {5'h00, 32'h8000_0040, 32'h3}) begin
      n_fail++; $display("FAIL int_exc exc=%h epc=%h bva=%h exp=00/80000040/3", cause_o[6:2], epc_o, badvaddr_o);
    end
    excepttype_i = 32'he;
    step();
    idle_inputs();
  endtask

  task automatic test_count_wrap();
    we_i = 1; waddr_i = 5'd9; wdata_i = 32'hffff_ffff;
    step();
    idle_inputs();
    n_checks++;
    if (count_o !== 32'hffff_ffff) begin n_fail++; $display("FAIL cnt_load got=%h exp=ffffffff", count_o); end
    step();
    n_checks++;
    if (count_o !== 32'hffff_ffff) begin n_fail++; $display("FAIL cnt_hold got=%h exp=ffffffff", count_o); end
    step();
    n_checks++;
    if (count_o !== 32'h0) begin n_fail++; $display("FAIL cnt_wrap got=%h exp=0", count_o); end
    we_i = 1; waddr_i = 5'd11; wdata_i = 32'h0000_0abc;
    step();
    idle_inputs();
    raddr_i = 5'd11;
    #1;
    n_checks++;
    if (rdata_o !== 32'h0000_0abc) begin n_fail++; $display("FAIL cmp_rd got=%h exp=00000abc", rdata_o); end
  endtask

  task automatic test_timer();
`ifdef CP0_TIMER_INT_EN
    int waited;
    do_reset();
    we_i = 1; waddr_i = 5'd11; wdata_i = 32'd4;
    step();
    idle_inputs();
    waited = 0;
    while (timer_int_o !== 1'b1 && waited < 30) begin step(); waited++; end
    n_checks++;
    if (timer_int_o !== 1'b1) begin n_fail++; $display("FAIL tint_rise got=%b exp=1 (timeout)", timer_int_o); end
    n_checks++;
    if (count_o !== 32'd4) begin n_fail++; $display("FAIL tint_count got=%h exp=4", count_o); end
    step(); step(); step();
    n_checks++;
    if (timer_int_o !== 1'b1 || cause_o[15] !== 1'b1) begin n_fail++; $display("FAIL tint_sticky tint=%b ip7=%b exp=1/1", timer_int_o, cause_o[15]); end
    we_i = 1; waddr_i = 5'd11; wdata_i = 32'd100;
    step();
    idle_inputs();
    n_checks++;
    if (timer_int_o !== 1'b0) begin n_fail++; $display("FAIL tint_clear got=%b exp=0", timer_int_o); end
`else
    int_i = 6'b100000;
    step();
    n_checks++;
    if (cause_o[15] !== 1'b1 || timer_int_o !== 1'b0) begin n_fail++; $display("FAIL ip7_ext ip7=%b tint=%b exp=1/0", cause_o[15], timer_int_o); end
    int_i = 0;
    step();
    n_checks++;
    if (cause_o[15] !== 1'b0) begin n_fail++; $display("FAIL ip7_low got=%b exp=0", cause_o[15]); end
`endif
  endtask

  task automatic test_reset_mid();
    we_i = 1; waddr_i = 5'd14; wdata_i = 32'h5555_aaaa; excepttype_i = 32'h5; bad_addr_i = 32'h77;
    @(negedge clk);
    rst = 1;
    #1;
    n_checks++;
    if (status_o !== 32'h0040_0000 || epc_o !== 32'h0 || count_o !== 32'h0) begin
      n_fail++; $display("FAIL async_rst status=%h epc=%h count=%h exp=00400000/0/0", status_o, epc_o, count_o);
    end
    step();
    n_checks++;
    if (epc_o !== 32'h0 || badvaddr_o !== 32'h0) begin n_fail++; $display("FAIL rst_prio epc=%h bva=%h exp=0/0", epc_o, badvaddr_o); end
    idle_inputs();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    int_i = 0; raddr_i = 0;
    test_reset();
    test_status_int();
    test_exception();
    test_nested();
    test_write_exc();
    test_count_wrap();
    test_timer();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
